// File: rtl/sm4_mask_pkg.sv
// Shared types and constants for the masked-SM4 random mask path.
package sm4_mask_pkg;
  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    ALARM  = 2'd2
  } disp_state_e;

  localparam int unsigned ERR_RCT  = 0;
  localparam int unsigned ERR_ZERO = 1;

  localparam int unsigned MASK_W = 128;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned LANES  = 16;
endpackage

// File: rtl/rand_mask_dispenser_if.sv
// Mask dispenser bus: source word in, mask handshake out, alarm/status out.
interface rand_mask_dispenser_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

  logic [sm4_mask_pkg::MASK_W-1:0] rand_in;
  logic                            mask_ready;
  logic                            mask_valid;
  logic [sm4_mask_pkg::MASK_W-1:0] mask_out;
  logic                            clear_alarm;
  logic                            alarm;
  logic [1:0]                      err_code;
  logic [FILL_W-1:0]               fill_level;

  modport master (
    input  rand_in, mask_ready, clear_alarm,
    output mask_valid, mask_out, alarm, err_code, fill_level
  );

  modport slave (
    output rand_in, mask_ready, clear_alarm,
    input  mask_valid, mask_out, alarm, err_code, fill_level
  );
endinterface

// File: rtl/rand_health_test.sv
// Online health tests on the raw mask source: repeated word and stuck-zero byte lanes.
module rand_health_test
  import sm4_mask_pkg::*;
#(
  parameter int unsigned RCT_LIMIT  = 3,
  parameter int unsigned ZERO_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MASK_W-1:0] rand_in,
  input  logic              enable,
  input  logic              clear,
  output logic              rct_fault,
  output logic              zero_fault
);
  localparam int unsigned REP_W = $clog2(RCT_LIMIT + 1);
  localparam int unsigned ZC_W  = $clog2(ZERO_LIMIT + 1);

  logic [MASK_W-1:0] prev;
  logic              prev_valid;
  logic [REP_W-1:0]  rep_cnt;
  logic [ZC_W-1:0]   zero_cnt [LANES];
  logic [LANES-1:0]  lane_zero;
  logic [LANES-1:0]  lane_hit;
  logic              same;

  // Faults look at the incoming word so the bad sample can be blocked on its own edge.
  always_comb begin
    same      = prev_valid && (rand_in == prev);
    rct_fault = same && ((32'(rep_cnt) + 32'd1) >= (RCT_LIMIT - 1));
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_zero[k] = (rand_in[k*LANE_W +: LANE_W] == '0);
      lane_hit[k]  = lane_zero[k] && ((32'(zero_cnt[k]) + 32'd1) >= ZERO_LIMIT);
    end
    zero_fault = |lane_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      rep_cnt    <= '0;
      for (int unsigned k = 0; k < LANES; k++) zero_cnt[k] <= '0;
    end else if (clear) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      rep_cnt    <= '0;
      for (int unsigned k = 0; k < LANES; k++) zero_cnt[k] <= '0;
    end else if (enable) begin
      prev       <= rand_in;
      prev_valid <= 1'b1;
      rep_cnt    <= same ? rep_cnt + 1'b1 : '0;
      for (int unsigned k = 0; k < LANES; k++)
        zero_cnt[k] <= lane_zero[k] ? zero_cnt[k] + 1'b1 : '0;
    end
  end
endmodule

// File: rtl/rand_mask_dispenser.sv
// Health-checked mask buffer between the free-running RNG and the SM4 round logic.
module rand_mask_dispenser
  import sm4_mask_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter int unsigned RCT_LIMIT     = 3,
  parameter int unsigned ZERO_LIMIT    = 4
) (
  input logic                   clk,
  input logic                   rst,
  rand_mask_dispenser_if.master bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam int unsigned WARM_W = $clog2(WARMUP_CYCLES + 1);

  disp_state_e       state, state_nx;
  logic [1:0]        err_q, err_nx;
  logic [WARM_W-1:0] warm_cnt;
  logic              warm_done;
  logic [MASK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FILL_W-1:0] fill;
  logic              rct_fault, zero_fault, fault, health_en, clr;
  logic              valid_i, push, pop;

  rand_health_test #(
    .RCT_LIMIT  (RCT_LIMIT),
    .ZERO_LIMIT (ZERO_LIMIT)
  ) u_health (
    .clk        (clk),
    .rst        (rst),
    .rand_in    (bus.rand_in),
    .enable     (health_en),
    .clear      (clr),
    .rct_fault  (rct_fault),
    .zero_fault (zero_fault)
  );

  always_comb begin
    health_en = (state != ALARM);
    clr       = (state == ALARM) && bus.clear_alarm;
    fault     = health_en && (rct_fault || zero_fault);
    warm_done = (32'(warm_cnt) == WARMUP_CYCLES - 1);
    valid_i   = (state == RUN) && (fill != '0);
    pop       = valid_i && bus.mask_ready;
    push      = (state == RUN) && !fault && ((32'(fill) < DEPTH) || pop);

    bus.mask_valid = valid_i;
    bus.mask_out   = valid_i ? mem[rd_ptr] : '0;
    bus.alarm      = (state == ALARM);
    bus.err_code   = err_q;
    bus.fill_level = fill;
  end

  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    unique case (state)
      WARMUP:  if (fault) state_nx = ALARM;
               else if (warm_done) state_nx = RUN;
      RUN:     if (fault) state_nx = ALARM;
      ALARM:   if (bus.clear_alarm) begin
                 state_nx = WARMUP;
                 err_nx   = '0;
               end
      default: state_nx = WARMUP;
    endcase
    if (fault) begin
      err_nx[ERR_RCT]  = rct_fault;
      err_nx[ERR_ZERO] = zero_fault;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WARMUP;
      err_q    <= '0;
      warm_cnt <= '0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      // Held at zero outside WARMUP so any re-entry restarts the discard count.
      if (state != WARMUP)  warm_cnt <= '0;
      else if (!warm_done)  warm_cnt <= warm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (fault) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rand_in;
  end
endmodule

// File: tb/tb_rand_mask_dispenser.sv
// Randomized bench for rand_mask_dispenser against a sample-history reference model.
module tb_rand_mask_dispenser;
  import sm4_mask_pkg::*;

  localparam int unsigned DEPTH         = 4;
  localparam int unsigned WARMUP_CYCLES = 16;
  localparam int unsigned RCT_LIMIT     = 3;
  localparam int unsigned ZERO_LIMIT    = 4;
  localparam int          HIST_KEEP     = 3;

  typedef logic [127:0] word_t;
  typedef enum int {M_WARM, M_RUN, M_ALARM} mphase_e;

  logic clk = 1'b0;
  logic rst;

  rand_mask_dispenser_if #(.DEPTH(DEPTH)) bus ();

  rand_mask_dispenser #(
    .DEPTH         (DEPTH),
    .WARMUP_CYCLES (WARMUP_CYCLES),
    .RCT_LIMIT     (RCT_LIMIT),
    .ZERO_LIMIT    (ZERO_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned edges = 0;

  mphase_e m_ph;
  int      m_samples;
  word_t   m_q[$];
  word_t   m_hist[$];
  logic [1:0] m_err;
  word_t   last_w;

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = M_WARM;
    m_samples = 0;
    m_q.delete();
    m_hist.delete();
    m_err = 2'b00;
  endtask

  function automatic bit lane_zero(input word_t w, input int k);
    return w[8*k +: 8] == 8'h00;
  endfunction

  task automatic model_step(input word_t w, input logic rdy, input logic clr);
    int    hn;
    bit    rep, zero, all;
    word_t h;
    if (m_ph == M_ALARM) begin
      if (clr) begin
        m_ph = M_WARM;
        m_samples = 0;
        m_err = 2'b00;
        m_hist.delete();
      end
    end else begin
      hn  = m_hist.size();
      rep = (hn >= int'(RCT_LIMIT) - 1);
      if (rep)
        for (int i = 1; i < int'(RCT_LIMIT); i++) begin
          h = m_hist[hn-i];
          if (h !== w) rep = 0;
        end
      zero = 0;
      if (hn >= int'(ZERO_LIMIT) - 1)
        for (int k = 0; k < 16; k++) begin
          all = lane_zero(w, k);
          for (int i = 1; i < int'(ZERO_LIMIT); i++) begin
            h = m_hist[hn-i];
            if (!lane_zero(h, k)) all = 0;
          end
          if (all) zero = 1;
        end
      m_hist.push_back(w);
      if (m_hist.size() > HIST_KEEP) void'(m_hist.pop_front());
      if (rep || zero) begin
        m_err = {zero, rep};
        m_ph  = M_ALARM;
        m_q.delete();
      end else if (m_ph == M_RUN) begin
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (m_q.size() < int'(DEPTH)) m_q.push_back(w);
      end else begin
        m_samples++;
        if (m_samples == int'(WARMUP_CYCLES)) m_ph = M_RUN;
      end
    end
  endtask

  task automatic compare_outputs();
    bit    v;
    word_t o;
    v = (m_ph == M_RUN) && (m_q.size() > 0);
    o = v ? m_q[0] : '0;
    check_eq("mask_valid", 128'(bus.mask_valid), 128'(v));
    check_eq("mask_out",   bus.mask_out, o);
    check_eq("fill_level", 128'(bus.fill_level), 128'(m_q.size()));
    check_eq("alarm",      128'(bus.alarm), 128'(m_ph == M_ALARM));
    check_eq("err_code",   128'(bus.err_code), 128'(m_err));
  endtask

  // Starts and ends at a falling edge.
  task automatic cycle(input word_t w, input logic rdy, input logic clr);
    compare_outputs();
    bus.rand_in     = w;
    bus.mask_ready  = rdy;
    bus.clear_alarm = clr;
    last_w = w;
    model_step(w, rdy, clr);
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  function automatic word_t rw();
    word_t w;
    for (int k = 0; k < 16; k++) w[8*k +: 8] = 8'($urandom_range(1, 255));
    return w;
  endfunction

  function automatic word_t inc_word(input int base);
    word_t w;
    for (int k = 0; k < 16; k++) w[8*k +: 8] = 8'(((base + k) % 255) + 1);
    return w;
  endfunction

  task automatic run_random(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(rw(), rdy, 1'b0);
  endtask

  task automatic clear_and_warm();
    cycle(rw(), 1'b1, 1'b1);
    run_random(WARMUP_CYCLES + 4, 1'b1);
  endtask

  initial begin
    int    first;
    word_t w, a5;
    int    r;

    rst = 1'b1;
    bus.rand_in = '0;
    bus.mask_ready = 1'b0;
    bus.clear_alarm = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    edges = 0;

    // Incrementing source, consumer always ready.
    first = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(inc_word(i), 1'b1, 1'b0);
      if (first == 0 && bus.mask_valid) first = int'(edges);
    end
    check_eq("first_valid_edge", 128'(first), 128'(WARMUP_CYCLES + 1));

    // Backpressure then full-FIFO drain with concurrent refill.
    run_random(8, 1'b0);
    check_eq("fill_saturated", 128'(bus.fill_level), 128'(DEPTH));
    run_random(4, 1'b1);
    check_eq("fill_full_pops", 128'(bus.fill_level), 128'(DEPTH));

    // Repetition fault.
    a5 = {16{8'hA5}};
    repeat (3) cycle(a5, 1'b1, 1'b0);
    check_eq("rct_alarm", 128'(bus.alarm), 128'(1));
    check_eq("rct_err",   128'(bus.err_code), 128'(2'b01));
    check_eq("rct_fill",  128'(bus.fill_level), 128'(0));
    run_random(3, 1'b1);
    check_eq("rct_sticky", 128'(bus.err_code), 128'(2'b01));
    clear_and_warm();

    // Lane 5 stuck at zero: three cycles tolerated, four alarm.
    for (int i = 0; i < 3; i++) begin
      w = rw(); w[47:40] = 8'h00; cycle(w, 1'b1, 1'b0);
    end
    cycle(rw(), 1'b1, 1'b0);
    check_eq("zero3_no_alarm", 128'(bus.alarm), 128'(0));
    for (int i = 0; i < 4; i++) begin
      w = rw(); w[47:40] = 8'h00; cycle(w, 1'b1, 1'b0);
    end
    check_eq("zero4_alarm", 128'(bus.alarm), 128'(1));
    check_eq("zero4_err",   128'(bus.err_code), 128'(2'b10));
    clear_and_warm();

    // Constant zero: the repeat test trips before the zero-lane test.
    repeat (6) cycle('0, 1'b1, 1'b0);
    check_eq("allzero_err", 128'(bus.err_code), 128'(2'b01));
    clear_and_warm();
    check_eq("resume_valid", 128'(bus.mask_valid), 128'(1));

    // Asynchronous reset with three words buffered.
    cycle(rw(), 1'b1, 1'b0);
    for (int i = 0; i < 10 && m_q.size() != 3; i++) cycle(rw(), 1'b0, 1'b0);
    check_eq("pre_rst_fill", 128'(bus.fill_level), 128'(3));
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 128'(bus.mask_valid), 128'(0));
    check_eq("arst_fill",  128'(bus.fill_level), 128'(0));
    check_eq("arst_alarm", 128'(bus.alarm), 128'(0));
    check_eq("arst_out",   bus.mask_out, 128'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    edges = 0;
    run_random(WARMUP_CYCLES + 6, 1'b1);

    // Mixed random traffic including repeats, zero lanes and clear pulses.
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15) w = last_w;
      else if (r < 35) begin
        w = rw(); w[8*(r%2) +: 8] = 8'h00;
      end else w = rw();
      cycle(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 6));
    end
    compare_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
